// File: rtl/ssd_scan_driver_if.sv
// ----------------------------------------------------------------------------
// ssd_scan_driver_if
//   Bundle of signals between the result-routing logic, the scan driver and
//   the board seven-segment pins.
//
//   value  [15:0]  word to display, digit0 = value[3:0] (rightmost)
//   load           capture value into the display register this cycle
//   enable         1 = scan display, 0 = all digits dark
//   a..g           segment cathodes, active-low
//   an0..an3       digit anodes, active-low, an0 = rightmost
//
//   master : the block supplying the word (and observing the pins)
//   slave  : ssd_scan_driver
// ----------------------------------------------------------------------------
interface ssd_scan_driver_if;
  logic [15:0] value;
  logic        load;
  logic        enable;
  logic        a, b, c, d, e, f, g;
  logic        an0, an1, an2, an3;

  modport master (
    output value, load, enable,
    input  a, b, c, d, e, f, g, an0, an1, an2, an3
  );

  modport slave (
    input  value, load, enable,
    output a, b, c, d, e, f, g, an0, an1, an2, an3
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// ----------------------------------------------------------------------------
// ssd_scan_driver
//   Latches a 16-bit result word on a load strobe and time-multiplexes it as
//   four hex digits onto a common-anode seven-segment display. Each digit is
//   lit for DIGIT_TICKS clock cycles; the scan order is an0, an1, an2, an3.
//   All pin outputs are registered and go dark while enable is low or while
//   reset is asserted.
//
//   Ports:
//     clk     system clock, rising edge
//     rst     asynchronous reset, active-low
//     bus     ssd_scan_driver_if.slave (value/load/enable in, a..g/an0..an3 out)
//
//   Parameters:
//     DIGIT_TICKS  clock cycles each digit stays lit (>= 2)
//     CNT_W        prescaler width, 2**CNT_W >= DIGIT_TICKS
//
//   Build option:
//     SSD_BLANK_ZEROS_EN  when defined, leading zero digits 3..1 are blanked
//                         (slot timing unchanged; digit 0 is always shown).
// ----------------------------------------------------------------------------
module ssd_scan_driver #(
  parameter int DIGIT_TICKS = 100000,
  parameter int CNT_W       = 17
) (
  input  logic               clk,
  input  logic               rst,
  ssd_scan_driver_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_TICKS - 1);

  // {a,b,c,d,e,f,g}, 0 = segment lit
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  logic [15:0]      shown_q, shown_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       idx_q,   idx_d;
  logic [6:0]       seg_q,   seg_d;
  logic [3:0]       an_q,    an_d;
  logic [3:0]       nibble;
  logic             blank;

  always_comb begin
    nibble = 4'h0;
    case (idx_q)
      2'd0:    nibble = shown_q[3:0];
      2'd1:    nibble = shown_q[7:4];
      2'd2:    nibble = shown_q[11:8];
      default: nibble = shown_q[15:12];
    endcase
  end

`ifdef SSD_BLANK_ZEROS_EN
  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd0:    blank = 1'b0;
      2'd1:    blank = (shown_q[15:4]  == 12'h000);
      2'd2:    blank = (shown_q[15:8]  == 8'h00);
      default: blank = (shown_q[15:12] == 4'h0);
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // Stage 0: display register, prescaler/index and the pin image computed
  // from the current index and shown word.
  always_comb begin
    shown_d = bus.load ? bus.value : shown_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seg_d   = 7'h7F;
    an_d    = 4'hF;
    if (bus.enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (!blank) begin
        seg_d = hex_to_seg(nibble);
        an_d  = ~(4'b0001 << idx_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shown_q <= 16'h0000;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      seg_q   <= 7'h7F;
      an_q    <= 4'hF;
    end else begin
      shown_q <= shown_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  // Stage 1: registered pins
  assign bus.a   = seg_q[6];
  assign bus.b   = seg_q[5];
  assign bus.c   = seg_q[4];
  assign bus.d   = seg_q[3];
  assign bus.e   = seg_q[2];
  assign bus.f   = seg_q[1];
  assign bus.g   = seg_q[0];
  assign bus.an0 = an_q[0];
  assign bus.an1 = an_q[1];
  assign bus.an2 = an_q[2];
  assign bus.an3 = an_q[3];

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  ssd_scan_driver_if bus ();

  ssd_scan_driver #(.DIGIT_TICKS(T), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: count of enabled edges within a frame and the shown word.
  int          m_n;
  logic [15:0] m_shown;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic [6:0]  SEG [16];

  logic [3:0] obs_an;
  logic [6:0] obs_seg;
  assign obs_an  = {bus.an3, bus.an2, bus.an1, bus.an0};
  assign obs_seg = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};

  initial begin
    SEG[0]  = 7'b0000001; SEG[1]  = 7'b1001111; SEG[2]  = 7'b0010010; SEG[3]  = 7'b0000110;
    SEG[4]  = 7'b1001100; SEG[5]  = 7'b0100100; SEG[6]  = 7'b0100000; SEG[7]  = 7'b0001111;
    SEG[8]  = 7'b0000000; SEG[9]  = 7'b0000100; SEG[10] = 7'b0001000; SEG[11] = 7'b1100000;
    SEG[12] = 7'b0110001; SEG[13] = 7'b1000010; SEG[14] = 7'b0110000; SEG[15] = 7'b0111000;
  end

  // Predict the pins after the coming edge from the present inputs, then take the edge.
  task automatic step();
    int          slot;
    logic [15:0] upper;
    logic        blanked;
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    if (bus.enable) begin
      slot    = (m_n / T) % 4;
      upper   = m_shown >> (4 * slot);
      blanked = 1'b0;
`ifdef SSD_BLANK_ZEROS_EN
      blanked = (slot != 0) && (upper == 16'h0000);
`endif
      if (!blanked) begin
        exp_an[slot] = 1'b0;
        exp_seg      = SEG[upper[3:0]];
      end
      m_n = (m_n + 1) % (4 * T);
    end
    if (bus.load) m_shown = bus.value;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    m_n     = 0;
    m_shown = 16'h0000;
    rst     = 1'b1;
  endtask

  task automatic test_reset();
    bus.enable = 1'b1;
    bus.load   = 1'b1;
    bus.value  = 16'hABCD;
    rst        = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if ({obs_an, obs_seg} !== {4'hF, 7'h7F}) begin
        fails++;
        $display("FAIL reset_dark cyc%0d: got an=%b seg=%b want an=1111 seg=1111111", i, obs_an, obs_seg);
      end
    end
    bus.load = 1'b0;
    do_reset();
  endtask

  task automatic test_scan_order();
    do_reset();
    bus.enable = 1'b0;
    bus.load   = 1'b1;
    bus.value  = 16'h1234;
    step();
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      tests++;
      if ({obs_an, obs_seg} !== {exp_an, exp_seg}) begin
        fails++;
        $display("FAIL scan_order cyc%0d: got an=%b seg=%b want an=%b seg=%b", i, obs_an, obs_seg, exp_an, exp_seg);
      end
      if (i == 1 || i == 17) begin
        tests++;
        if ({obs_an, obs_seg} !== {4'b1110, 7'b1001100}) begin
          fails++;
          $display("FAIL scan_an0_digit4 cyc%0d: got an=%b seg=%b want an=1110 seg=1001100", i, obs_an, obs_seg);
        end
      end
      if (i == 13) begin
        tests++;
        if ({obs_an, obs_seg} !== {4'b0111, 7'b1001111}) begin
          fails++;
          $display("FAIL scan_an3_digit1: got an=%b seg=%b want an=0111 seg=1001111", obs_an, obs_seg);
        end
      end
    end
  endtask

  task automatic test_decode_sweep();
    logic [15:0] vals [3];
    vals[0] = 16'h89AB; vals[1] = 16'hCDEF; vals[2] = 16'h0567;
    bus.enable = 1'b1;
    for (int v = 0; v < 3; v++) begin
      bus.load  = 1'b1;
      bus.value = vals[v];
      step();
      bus.load = 1'b0;
      for (int i = 0; i < 4 * T; i++) begin
        step();
        tests++;
        if ({obs_an, obs_seg} !== {exp_an, exp_seg}) begin
          fails++;
          $display("FAIL decode_%h cyc%0d: got an=%b seg=%b want an=%b seg=%b", vals[v], i, obs_an, obs_seg, exp_an, exp_seg);
        end
      end
    end
  endtask

  task automatic test_midslot_load();
    int guard;
    bus.enable = 1'b1;
    bus.load   = 1'b1;
    bus.value  = 16'h1234;
    step();
    bus.load = 1'b0;
    guard = 0;
    while (m_n != T + 1 && guard < 32) begin
      step();
      guard++;
    end
    tests++;
    if (m_n != T + 1) begin
      fails++;
      $display("FAIL midslot_reach: got n=%0d want n=%0d", m_n, T + 1);
    end
    bus.load  = 1'b1;
    bus.value = 16'hFFFF;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 2 * T; i++) begin
      step();
      tests++;
      if ({obs_an, obs_seg} !== {exp_an, exp_seg}) begin
        fails++;
        $display("FAIL midslot cyc%0d: got an=%b seg=%b want an=%b seg=%b", i, obs_an, obs_seg, exp_an, exp_seg);
      end
      if (i == 0) begin
        tests++;
        if ({obs_an, obs_seg} !== {4'b1101, 7'b0111000}) begin
          fails++;
          $display("FAIL midslot_F_on_an1: got an=%b seg=%b want an=1101 seg=0111000", obs_an, obs_seg);
        end
      end
    end
  endtask

  task automatic test_enable_hold();
    int guard;
    bus.enable = 1'b1;
    bus.load   = 1'b1;
    bus.value  = 16'h1234;
    step();
    bus.load = 1'b0;
    guard = 0;
    while (m_n != 2 * T + 2 && guard < 32) begin
      step();
      guard++;
    end
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if ({obs_an, obs_seg} !== {4'hF, 7'h7F}) begin
        fails++;
        $display("FAIL enable_hold_dark cyc%0d: got an=%b seg=%b want an=1111 seg=1111111", i, obs_an, obs_seg);
      end
    end
    bus.enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if ({obs_an, obs_seg} !== {exp_an, exp_seg}) begin
        fails++;
        $display("FAIL enable_resume cyc%0d: got an=%b seg=%b want an=%b seg=%b", i, obs_an, obs_seg, exp_an, exp_seg);
      end
      tests++;
      if (obs_an !== ((i < 2) ? 4'b1011 : 4'b0111)) begin
        fails++;
        $display("FAIL enable_resume_anode cyc%0d: got an=%b want an=%b", i, obs_an, (i < 2) ? 4'b1011 : 4'b0111);
      end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] vals [3];
    vals[0] = 16'h0005; vals[1] = 16'h0000; vals[2] = 16'h0105;
    bus.enable = 1'b1;
    for (int v = 0; v < 3; v++) begin
      bus.load  = 1'b1;
      bus.value = vals[v];
      step();
      bus.load = 1'b0;
      for (int i = 0; i < 4 * T; i++) begin
        step();
        tests++;
        if ({obs_an, obs_seg} !== {exp_an, exp_seg}) begin
          fails++;
          $display("FAIL blank_%h cyc%0d: got an=%b seg=%b want an=%b seg=%b", vals[v], i, obs_an, obs_seg, exp_an, exp_seg);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.enable = ($urandom_range(0, 7) != 0);
      bus.load   = ($urandom_range(0, 9) == 0);
      bus.value  = 16'($urandom);
      step();
      tests++;
      if ({obs_an, obs_seg} !== {exp_an, exp_seg}) begin
        fails++;
        $display("FAIL random cyc%0d: got an=%b seg=%b want an=%b seg=%b", i, obs_an, obs_seg, exp_an, exp_seg);
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_reset_midscan();
    bus.enable = 1'b1;
    bus.load   = 1'b1;
    bus.value  = 16'h8888;
    step();
    bus.load = 1'b0;
    step();
    tests++;
    if (obs_an === 4'hF) begin
      fails++;
      $display("FAIL midscan_lit_before_reset: got an=%b want one anode low", obs_an);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({obs_an, obs_seg} !== {4'hF, 7'h7F}) begin
      fails++;
      $display("FAIL reset_midscan_async: got an=%b seg=%b want an=1111 seg=1111111", obs_an, obs_seg);
    end
    do_reset();
  endtask

  initial begin
    bus.value  = 16'h0000;
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    m_n        = 0;
    m_shown    = 16'h0000;
    test_reset();
    test_scan_order();
    test_decode_sweep();
    test_midslot_load();
    test_enable_hold();
    test_blanking();
    test_random();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
